// File: rtl/nibble_serial_adder_if.sv
// Handshake and operand/result bundle for nibble_serial_adder.
// master: requester (start, a, b, carry_in); slave: adder (busy, done, sum, carry_out).
interface nibble_serial_adder_if #(
    parameter int NUM_NIBBLES = 4
);
    localparam int WIDTH = 4 * NUM_NIBBLES;

    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             carry_in;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum;
    logic             carry_out;

    modport master (
        output start, a, b, carry_in,
        input  busy, done, sum, carry_out
    );

    modport slave (
        input  start, a, b, carry_in,
        output busy, done, sum, carry_out
    );
endinterface

// File: rtl/nibble_serial_adder.sv
// Wide unsigned adder that reuses one 4-bit ripple adder, one nibble per cycle.
// Ports: clk, rst (sync, active high), bus (slave: start/a/b/carry_in in, busy/done/sum/carry_out out).

// 4-bit ripple-carry adder shared by the serial controller.
// Ports: a_i, b_i (4-bit), c_i carry in; sum_o (4-bit), c_o carry out.
module adder_4bit (
    input  logic [3:0] a_i,
    input  logic [3:0] b_i,
    input  logic       c_i,
    output logic [3:0] sum_o,
    output logic       c_o
);
    logic [4:0] c;

    always_comb begin
        c     = '0;
        sum_o = '0;
        c[0]  = c_i;
        for (int i = 0; i < 4; i++) begin
            sum_o[i] = a_i[i] ^ b_i[i] ^ c[i];
            c[i+1]   = (a_i[i] & b_i[i]) | (c[i] & (a_i[i] ^ b_i[i]));
        end
        c_o = c[4];
    end
endmodule

module nibble_serial_adder #(
    parameter int NUM_NIBBLES = 4
) (
    input logic                  clk,
    input logic                  rst,
    nibble_serial_adder_if.slave bus
);
    localparam int WIDTH = 4 * NUM_NIBBLES;
    localparam int IDXW  = (NUM_NIBBLES > 2) ? $clog2(NUM_NIBBLES) : 1;
    localparam logic [IDXW-1:0] LAST = IDXW'(NUM_NIBBLES - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADD  = 2'd1,
        DONE = 2'd2
    } state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] work_q, work_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             c_q, c_d;
    logic             cout_q, cout_d;
    logic [IDXW-1:0]  idx_q, idx_d;

    logic [3:0] add_sum;
    logic       add_co;
    logic       busy_o;
    logic       done_o;

    adder_4bit u_add (
        .a_i   (a_q[4*idx_q +: 4]),
        .b_i   (b_q[4*idx_q +: 4]),
        .c_i   (c_q),
        .sum_o (add_sum),
        .c_o   (add_co)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            work_q  <= '0;
            sum_q   <= '0;
            c_q     <= 1'b0;
            cout_q  <= 1'b0;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            work_q  <= work_d;
            sum_q   <= sum_d;
            c_q     <= c_d;
            cout_q  <= cout_d;
            idx_q   <= idx_d;
        end
    end

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        work_d  = work_q;
        sum_d   = sum_q;
        c_d     = c_q;
        cout_d  = cout_q;
        idx_d   = idx_q;
        unique case (state_q)
            IDLE: begin
                if (bus.start) begin
                    a_d     = bus.a;
                    b_d     = bus.b;
                    c_d     = bus.carry_in;
                    idx_d   = '0;
                    state_d = ADD;
                end
            end
            ADD: begin
                work_d[4*idx_q +: 4] = add_sum;
                c_d = add_co;
                if (idx_q == LAST) begin
                    // work_d already holds the final nibble this cycle
                    sum_d   = work_d;
                    cout_d  = add_co;
                    state_d = DONE;
                end else begin
                    idx_d = idx_q + IDXW'(1);
                end
            end
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        busy_o = 1'b0;
        done_o = 1'b0;
        unique case (state_q)
            IDLE: ;
            ADD:  busy_o = 1'b1;
            DONE: begin
                busy_o = 1'b1;
                done_o = 1'b1;
            end
            default: ;
        endcase
    end

    assign bus.busy      = busy_o;
    assign bus.done      = done_o;
    assign bus.sum       = sum_q;
    assign bus.carry_out = cout_q;
endmodule

// File: doc/nibble_serial_adder.md
# nibble_serial_adder

Multi-cycle adder controller that computes a WIDTH-bit sum (WIDTH = 4·NUM_NIBBLES) by sequencing one shared instance of the team's 4-bit ripple adder (`adder_4bit`) over the operand nibbles, LSB nibble first. It registers the carry between passes and exposes a start/busy/done handshake. It sits between a requester (control FSM or testbench) and the 4-bit adder datapath, so wide additions reuse a single small adder.

## Interface
- NUM_NIBBLES, 4: number of 4-bit passes; WIDTH = 4·NUM_NIBBLES (default 16); legal range 2..16.
- clk  in  1  rising-edge clock; the block has one clock.
- rst  in  1  synchronous, active-high reset.
- start  in  1  request; sampled only in IDLE.
- a  in  WIDTH  operand A; captured on an accepted start.
- b  in  WIDTH  operand B; captured on an accepted start.
- carry_in  in  1  initial carry; captured on an accepted start.
- busy  out  1  high in ADD and DONE.
- done  out  1  one-cycle pulse; result valid.
- sum  out  WIDTH  result register; holds its value until the next completion.
- carry_out  out  1  final carry from the MSB nibble pass; holds with sum.

## Operation
- Internal registers:
  - a_reg and b_reg (WIDTH bits): captured operands.
  - work (WIDTH bits): partial sum.
  - c_reg: running carry.
  - idx (ceil(log2 NUM_NIBBLES) bits): nibble index.
  - state.
- The single adder_4bit instance has these inputs: a_reg[4·idx+3:4·idx], b_reg[4·idx+3:4·idx], c_reg. Its carry-out port feeds c_reg.
- FSM states are IDLE, ADD and DONE.
  - IDLE: if start = 1, capture a, b and carry_in into a_reg, b_reg and c_reg. Clear idx to 0 and move to ADD. If start = 0, stay in IDLE.
  - ADD: on each clock edge, write the adder's 4-bit sum into work nibble idx. Load c_reg with the adder's carry-out.
    - If idx = NUM_NIBBLES−1, copy the completed work into sum, copy the final carry into carry_out, and move to DONE.
    - Otherwise, increment idx.
  - DONE: done = 1 for exactly this cycle, then move unconditionally to IDLE.
- start is ignored while busy = 1, including during the DONE cycle. Ignored requests are not queued; the requester must reassert start once busy = 0.
- Arithmetic: unsigned, modulo 2^WIDTH. {carry_out, sum} = a + b + carry_in exactly.
- sum and carry_out change only on the edge that enters DONE. Partial results are never visible on sum.
- Operand inputs may change after the start cycle without affecting the result.

## Timing
- Reset: while rst = 1 at a rising edge, all registers clear.
  - state = IDLE; busy = 0, done = 0, sum = 0, carry_out = 0.
  - a_reg, b_reg, work, c_reg and idx are all 0.
  - Reset takes priority over start.
- Reset during ADD or DONE aborts the operation. The result is discarded and done does not pulse.
- Latency: start is accepted at edge E0.
  - busy = 1 from E0 through the DONE cycle.
  - ADD occupies the NUM_NIBBLES cycles after E0.
  - done = 1 in the cycle after edge E0+NUM_NIBBLES, i.e. done is visible NUM_NIBBLES+1 cycles after the start cycle.
- Throughput: at most one addition per NUM_NIBBLES+2 cycles. The earliest next start is sampled in the first IDLE cycle after DONE.
- busy, done, sum and carry_out are all registered outputs; none of them depends combinationally on an input.

## Test plan
- Reset: hold rst for 2 cycles with start = 1 and random operands.
  - Required: busy = 0, done = 0, sum = 0x0000 and carry_out = 0 throughout.
  - Required: no operation begins until start is sampled after rst falls.
- Basic add (NUM_NIBBLES = 4): a = 0x1234, b = 0x4321, carry_in = 0, start pulsed for 1 cycle.
  - Required: done is high exactly 5 cycles after the start cycle, for 1 cycle.
  - Required: sum = 0x5555 and carry_out = 0, both held afterwards.
- Full carry ripple: a = 0xFFFF, b = 0x0001, carry_in = 0 gives sum = 0x0000, carry_out = 1. Then a = 0xFFFF, b = 0x0000, carry_in = 1 gives sum = 0x0000, carry_out = 1.
- Busy protection: start a = 0x00F0, b = 0x0010. Pulse start with a = 0x1111 during ADD and again during DONE.
  - Required: a single done pulse with sum = 0x0100, carry_out = 0.
  - Required: no second operation begins.
- Operand hold: start with a = 0x8000, b = 0x8000, then change a and b every cycle while busy.
  - Required: sum = 0x0000, carry_out = 1.
- Reset mid-operation: assert rst for 1 cycle at the 2nd ADD cycle.
  - Required: no done pulse; sum = 0x0000 and carry_out = 0 afterwards.
  - Then start a = 0x0001, b = 0x0002: sum = 0x0003 with normal latency.
- Randomized back-to-back: 1000 random a, b and carry_in values, with each start issued in the first IDLE cycle after done. Required: {carry_out, sum} = a + b + carry_in every time.
